// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl
//   Direct-mapped, write-through cache controller placed in front of a
//   single-ported block storage array.  It keeps the tag/valid state and
//   drives the array's enable/write/data interface.  A read miss fetches the
//   word from memory over a req/ack handshake and fills the line.  Writes
//   always go through to memory.  A write hit also updates the line.  A write
//   miss does not allocate a line.
//
//   Vectors use [0:N-1] numbering, so bit 0 is the MSB.  The tag is the upper
//   ADDR_W-INDEX_W address bits and the index is the low INDEX_W bits.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata         CPU request; held until cpu_done
//   cpu_rdata/done/hit            completion pulse with read data and hit flag
//   flush                         invalidate every line (IDLE only)
//   blk_index/enable/write/data   block array control and write data
//   blk_q                         block array read data (combinational)
//   mem_req/we/addr/wdata         memory request, held until mem_ack
//   mem_ack/mem_rdata             memory completion and read data
//   hit_cnt/miss_cnt              saturating lookup statistics
// ---------------------------------------------------------------------------
module cache_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 4,
  parameter int DATA_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [0:ADDR_W-1]   cpu_addr,
  input  logic [0:DATA_W-1]   cpu_wdata,
  output logic [0:DATA_W-1]   cpu_rdata,
  output logic                cpu_done,
  output logic                cpu_hit,
  input  logic                flush,
  output logic [0:INDEX_W-1]  blk_index,
  output logic                blk_enable,
  output logic                blk_write,
  output logic [0:DATA_W-1]   blk_data,
  input  logic [0:DATA_W-1]   blk_q,
  output logic                mem_req,
  output logic                mem_we,
  output logic [0:ADDR_W-1]   mem_addr,
  output logic [0:DATA_W-1]   mem_wdata,
  input  logic                mem_ack,
  input  logic [0:DATA_W-1]   mem_rdata,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_FILL   = 3'd2,
    S_WMEM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Control state: reset
  logic [0:LINES-1] valid_q, valid_d;
  logic [15:0]      hit_cnt_q, hit_cnt_d;
  logic [15:0]      miss_cnt_q, miss_cnt_d;

  // Request/data state: not reset. Every output that carries it is gated by
  // state, so stale or unknown contents are never visible after a reset.
  logic              we_q;
  logic [0:ADDR_W-1] addr_q;
  logic [0:DATA_W-1] wdata_q;
  logic [0:DATA_W-1] rdata_q;
  logic              hit_q;
  logic [0:TAG_W-1]  tag_ram_q [LINES];

  logic [0:TAG_W-1]   tag_w;
  logic [0:INDEX_W-1] idx_w;
  logic               lookup_hit;
  logic               accept;

  assign tag_w      = addr_q[0:TAG_W-1];
  assign idx_w      = addr_q[TAG_W:ADDR_W-1];
  assign lookup_hit = valid_q[idx_w] && (tag_ram_q[idx_w] == tag_w);
  // Flush takes priority over a new request in IDLE.
  assign accept     = (state_q == S_IDLE) && !flush && cpu_req;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------- FSM state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (we_q)            state_d = S_WMEM;
        else if (lookup_hit) state_d = S_DONE;
        else                 state_d = S_FILL;
      end
      S_FILL: begin
        if (mem_ack) state_d = S_DONE;
      end
      S_WMEM: begin
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM outputs ----------------
  always_comb begin
    cpu_done   = 1'b0;
    cpu_hit    = 1'b0;
    cpu_rdata  = '0;
    blk_index  = '0;
    blk_enable = 1'b0;
    blk_write  = 1'b0;
    blk_data   = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      S_LOOKUP: begin
        blk_enable = 1'b1;
        blk_index  = idx_w;
        // Write hit: update the line now. The memory write follows in WMEM.
        if (we_q && lookup_hit) begin
          blk_write = 1'b1;
          blk_data  = wdata_q;
        end
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        // The returning word is written into the line in the ack cycle.
        if (mem_ack) begin
          blk_enable = 1'b1;
          blk_write  = 1'b1;
          blk_index  = idx_w;
          blk_data   = mem_rdata;
        end
      end
      S_WMEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      S_DONE: begin
        cpu_done  = 1'b1;
        cpu_hit   = hit_q;
        cpu_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  // ---------------- valid bits and statistics ----------------
  always_comb begin
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_IDLE && flush) begin
      valid_d = '0;
    end
    if (state_q == S_LOOKUP) begin
      if (lookup_hit) hit_cnt_d  = sat_inc(hit_cnt_q);
      else            miss_cnt_d = sat_inc(miss_cnt_q);
    end
    if (state_q == S_FILL && mem_ack) begin
      valid_d[idx_w] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // ---------------- request capture, tag RAM, read data ----------------
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= cpu_we;
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
    end
    if (state_q == S_LOOKUP) begin
      hit_q <= lookup_hit;
      if (lookup_hit && !we_q) rdata_q <= blk_q;
    end
    if (state_q == S_FILL && mem_ack) begin
      tag_ram_q[idx_w] <= tag_w;
      rdata_q          <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl
//   Directed bench for cache_ctrl. It models the block array and a memory
//   that acknowledges ACK_DLY cycles after mem_req is first seen. Directed
//   CPU transactions come from a vector table. Hand-written sequences cover
//   flush priority, a stray mem_ack while idle, and a reset during a fill.
// ---------------------------------------------------------------------------
module tb_cache_ctrl;

  localparam int ACK_DLY = 3;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [0:15] cpu_addr;
  logic [0:15] cpu_wdata;
  logic [0:15] cpu_rdata;
  logic        cpu_done;
  logic        cpu_hit;
  logic        flush;
  logic [0:3]  blk_index;
  logic        blk_enable;
  logic        blk_write;
  logic [0:15] blk_data;
  logic [0:15] blk_q;
  logic        mem_req;
  logic        mem_we;
  logic [0:15] mem_addr;
  logic [0:15] mem_wdata;
  logic        mem_ack;
  logic [0:15] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  cache_ctrl #(.ADDR_W(16), .INDEX_W(4), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_done   (cpu_done),
    .cpu_hit    (cpu_hit),
    .flush      (flush),
    .blk_index  (blk_index),
    .blk_enable (blk_enable),
    .blk_write  (blk_write),
    .blk_data   (blk_data),
    .blk_q      (blk_q),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block storage array model
  logic [15:0] blk_mem [16];
  always @(posedge clk) begin
    if (blk_enable && blk_write) blk_mem[blk_index] <= blk_data;
  end
  assign blk_q = blk_enable ? blk_mem[blk_index] : 16'h0000;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Observations from the last transaction
  logic        r_done, r_hit, r_mem, r_mem_we, r_blkw;
  logic [15:0] r_rdata, r_mem_addr, r_mem_wdata, r_blkw_data;
  int          r_cycles;

  // Runs one CPU transaction and acts as the memory. The count c is the
  // number of clock edges after the request is presented, so the first edge
  // is the accept edge.
  task automatic run_txn(input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] mdata);
    int memcnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    r_done = 0; r_hit = 0; r_mem = 0; r_mem_we = 0; r_blkw = 0;
    r_rdata = 0; r_mem_addr = 0; r_mem_wdata = 0; r_blkw_data = 0; r_cycles = 0;
    memcnt = 0;
    for (int c = 1; c <= 40 && !r_done; c++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      r_cycles = c;
      if (cpu_done) begin
        r_done = 1; r_hit = cpu_hit; r_rdata = cpu_rdata;
        cpu_req = 1'b0;
      end else begin
        if (mem_req) begin
          r_mem = 1; r_mem_we = mem_we; r_mem_addr = mem_addr; r_mem_wdata = mem_wdata;
          memcnt++;
          if (memcnt == ACK_DLY) begin
            mem_ack = 1'b1; mem_rdata = mdata;
          end
        end
        #1;
        if (blk_enable && blk_write) begin
          r_blkw = 1; r_blkw_data = blk_data;
        end
      end
    end
    cpu_req = 1'b0; mem_ack = 1'b0;
    if (r_done) @(posedge clk);  // DONE -> IDLE
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdata;
    logic        exp_hit;
    logic        chk_rdata;
    logic [15:0] exp_rdata;
    logic        exp_mem;
    logic        exp_mem_we;
    logic        exp_blkw;
    int          exp_cyc;
    logic [15:0] exp_hcnt;
    logic [15:0] exp_mcnt;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b0, 16'h0013, 16'h0000, 16'h0F0F, 1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b0, 1'b1, 5, 16'd0, 16'd1};
    vecs[1] = '{1'b0, 16'h0013, 16'h0000, 16'hDEAD, 1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b0, 1'b0, 2, 16'd1, 16'd1};
    vecs[2] = '{1'b0, 16'h0023, 16'h0000, 16'hAAAA, 1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b1, 5, 16'd1, 16'd2};
    vecs[3] = '{1'b1, 16'h0023, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 5, 16'd2, 16'd2};
    vecs[4] = '{1'b0, 16'h0023, 16'h0000, 16'hDEAD, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 2, 16'd3, 16'd2};
    vecs[5] = '{1'b0, 16'h0013, 16'h0000, 16'h5555, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, 5, 16'd3, 16'd3};
    vecs[6] = '{1'b1, 16'h0044, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 5, 16'd3, 16'd4};
    vecs[7] = '{1'b0, 16'h0044, 16'h0000, 16'h7777, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b0, 1'b1, 5, 16'd3, 16'd5};
    vecs[8] = '{1'b0, 16'h0044, 16'h0000, 16'hDEAD, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 2, 16'd4, 16'd5};

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_done", cpu_done, 0);
    check("rst_blk_enable", blk_enable, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {cpu_done, cpu_hit, blk_enable, blk_write, mem_req, mem_we}, 0);

    // Table-driven transactions
    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mdata);
      check($sformatf("v%0d_done", i), r_done, 1);
      check($sformatf("v%0d_cycles", i), r_cycles, vecs[i].exp_cyc);
      check($sformatf("v%0d_hit", i), r_hit, vecs[i].exp_hit);
      if (vecs[i].chk_rdata)
        check($sformatf("v%0d_rdata", i), r_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_mem_req", i), r_mem, vecs[i].exp_mem);
      if (vecs[i].exp_mem) begin
        check($sformatf("v%0d_mem_we", i), r_mem_we, vecs[i].exp_mem_we);
        check($sformatf("v%0d_mem_addr", i), r_mem_addr, vecs[i].addr);
        if (vecs[i].we)
          check($sformatf("v%0d_mem_wdata", i), r_mem_wdata, vecs[i].wdata);
      end
      check($sformatf("v%0d_blk_write", i), r_blkw, vecs[i].exp_blkw);
      if (vecs[i].exp_blkw) begin
        check($sformatf("v%0d_blk_data", i), r_blkw_data,
              vecs[i].we ? vecs[i].wdata : vecs[i].mdata);
        check($sformatf("v%0d_blk_line", i), blk_mem[vecs[i].addr[3:0]],
              vecs[i].we ? vecs[i].wdata : vecs[i].mdata);
      end
      check($sformatf("v%0d_hit_cnt", i), hit_cnt, vecs[i].exp_hcnt);
      check($sformatf("v%0d_miss_cnt", i), miss_cnt, vecs[i].exp_mcnt);
    end

    // A stray mem_ack while idle must not start anything
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    check("stray_ack_idle", {blk_enable, cpu_done, mem_req}, 0);
    @(negedge clk);
    mem_ack = 1'b0;

    // flush together with cpu_req: flush wins, the request is not accepted
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0044;
    @(posedge clk); #1;
    check("flush_priority", {blk_enable, cpu_done}, 0);
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    check("flush_keeps_hit_cnt", hit_cnt, 16'd4);
    check("flush_keeps_miss_cnt", miss_cnt, 16'd5);
    run_txn(1'b0, 16'h0044, 16'h0000, 16'h7777);
    check("post_flush_done", r_done, 1);
    check("post_flush_hit", r_hit, 0);
    check("post_flush_mem_req", r_mem, 1);
    check("post_flush_miss_cnt", miss_cnt, 16'd6);

    // Reset asserted during a FILL with mem_req high
    begin
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0013;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(posedge clk); #1;
        if (mem_req) seen = 1'b1;
      end
      check("fill_mem_req_seen", seen, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_mem_req", mem_req, 0);
      check("rst_mid_hit_cnt", hit_cnt, 0);
      check("rst_mid_miss_cnt", miss_cnt, 0);
      cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    run_txn(1'b0, 16'h0044, 16'h0000, 16'h7777);
    check("after_rst_done", r_done, 1);
    check("after_rst_hit", r_hit, 0);
    check("after_rst_rdata", r_rdata, 16'h7777);
    check("after_rst_hit_cnt", hit_cnt, 16'd0);
    check("after_rst_miss_cnt", miss_cnt, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
